// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up initialisation sequencer
//
// Drives the JEDEC-style SDRAM power-up sequence in this order:
//   wait T_WAIT -> PRECHARGE ALL -> T_RP -> N x (AUTO REFRESH -> T_RFC)
//   -> LOAD MODE -> T_MRD -> done
// Once the sequence finishes, init_done stays high until the next reset.
//
// Configuration macro: SDRAM_INIT_8REF_EN
//   defined   -> N = 8 auto refreshes
//   undefined -> N = 2 auto refreshes
//
// Ports:
//   clk_133    in   1   sole clock; all logic runs on its rising edge
//   rst_133    in   1   asynchronous active-high reset; release is already
//                       synchronised upstream
//   cke        out  1   SDRAM clock enable
//   cs_n       out  1   SDRAM chip select, active-low
//   ras_n      out  1   SDRAM row address strobe, active-low
//   cas_n      out  1   SDRAM column address strobe, active-low
//   we_n       out  1   SDRAM write enable, active-low
//   ba         out  2   bank address
//   addr       out  13  SDRAM address
//   init_done  out  1   sticky flag, high once initialisation is complete
//
// All outputs are registered.

module sdram_init_seq #(
  parameter logic [15:0] T_WAIT   = 16'd26600,
  parameter logic [15:0] T_RP     = 16'd3,
  parameter logic [15:0] T_RFC    = 16'd10,
  parameter logic [15:0] T_MRD    = 16'd2,
  parameter logic [12:0] MODE_REG = 13'h0037
) (
  input  logic        clk_133,
  input  logic        rst_133,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        init_done
);

`ifdef SDRAM_INIT_8REF_EN
  localparam logic [3:0] N_REF = 4'd8;
`else
  localparam logic [3:0] N_REF = 4'd2;
`endif

  // Command encodings, ordered {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam logic [3:0] CMD_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_PRE  = 3'd1,
    S_TRP  = 3'd2,
    S_REF  = 3'd3,
    S_TRFC = 3'd4,
    S_MRS  = 3'd5,
    S_TMRD = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;       // cycles spent in the current state, this one included
  logic [3:0]  ref_cnt;   // auto refreshes issued so far

  logic        nxt_cke;
  logic [3:0]  nxt_cmd;
  logic [1:0]  nxt_ba;
  logic [12:0] nxt_addr;
  logic        nxt_done;

  // State register. The outputs are registered from the next-state decode,
  // so the value on the pins always matches the state entered at that edge.
  always_ff @(posedge clk_133 or posedge rst_133) begin
    if (rst_133) begin
      state     <= S_WAIT;
      cnt       <= 16'd0;
      ref_cnt   <= 4'd0;
      cke       <= 1'b0;
      {cs_n, ras_n, cas_n, we_n} <= CMD_IDLE;
      ba        <= 2'd0;
      addr      <= 13'd0;
      init_done <= 1'b0;
    end else begin
      state <= next_state;
      // The counter restarts at 1 on every state entry. Each wait state exits
      // on equality with its limit, so the counter never gets past 65535. The
      // saturation is only a guard.
      if (next_state != state) begin
        cnt <= 16'd1;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
      if (state == S_REF) begin
        ref_cnt <= ref_cnt + 4'd1;
      end
      cke       <= nxt_cke;
      {cs_n, ras_n, cas_n, we_n} <= nxt_cmd;
      ba        <= nxt_ba;
      addr      <= nxt_addr;
      init_done <= nxt_done;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_WAIT: if (cnt == T_WAIT) next_state = S_PRE;
      S_PRE:  next_state = S_TRP;
      S_TRP:  if (cnt == T_RP) next_state = S_REF;
      S_REF:  next_state = S_TRFC;
      S_TRFC: begin
        if (cnt == T_RFC) begin
          next_state = (ref_cnt == N_REF) ? S_MRS : S_REF;
        end
      end
      S_MRS:  next_state = S_TMRD;
      S_TMRD: if (cnt == T_MRD) next_state = S_DONE;
      S_DONE: next_state = S_DONE;
      default: next_state = S_WAIT;
    endcase
  end

  // Output decode of the state being entered. ba and addr stay 0 except on
  // the command cycles that carry an address.
  always_comb begin
    nxt_cke  = 1'b1;
    nxt_cmd  = CMD_NOP;
    nxt_ba   = 2'd0;
    nxt_addr = 13'd0;
    nxt_done = init_done;
    case (next_state)
      S_PRE: begin
        nxt_cmd  = CMD_PRE;
        nxt_addr = 13'h0400;  // A10 high selects all banks
      end
      S_REF: nxt_cmd = CMD_REF;
      S_MRS: begin
        nxt_cmd  = CMD_LMR;
        nxt_addr = MODE_REG;
      end
      S_DONE: nxt_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - scoreboard testbench for sdram_init_seq
module tb_sdram_init_seq;

  localparam logic [12:0] MODE = 13'h0A5B;
`ifdef SDRAM_INIT_8REF_EN
  localparam int MRS_C  = 78;
  localparam int DONE_C = 81;
`else
  localparam int MRS_C  = 30;
  localparam int DONE_C = 33;
`endif
  localparam int PRE_C  = 11;
  localparam int REF0_C = 14;
  localparam int REF_STEP = 8;

  typedef struct {
    int          cyc;
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke, cs_n, ras_n, cas_n, we_n, init_done;
  logic [1:0]  ba;
  logic [12:0] addr;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] prev_cmd = 4'b1111;

  sdram_init_seq #(
    .T_WAIT(16'd10), .T_RP(16'd2), .T_RFC(16'd7), .T_MRD(16'd2), .MODE_REG(MODE)
  ) dut (
    .clk_133(clk), .rst_133(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Cycle number since reset release; 0 while in reset.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic exp_t exp_at(int c);
    exp_t e;
    e.cyc  = c;
    e.cke  = 1'b1;
    e.cmd  = 4'b0111;
    e.ba   = 2'd0;
    e.addr = 13'd0;
    e.done = (c >= DONE_C);
    if (c == PRE_C) begin
      e.cmd  = 4'b0010;
      e.addr = 13'h0400;
    end else if (c >= REF0_C && c < MRS_C && ((c - REF0_C) % REF_STEP) == 0) begin
      e.cmd = 4'b0001;
    end else if (c == MRS_C) begin
      e.cmd  = 4'b0000;
      e.addr = MODE;
    end
    return e;
  endfunction

  function automatic exp_t exp_rst();
    exp_t e;
    e.cyc  = 0;
    e.cke  = 1'b0;
    e.cmd  = 4'b1111;
    e.ba   = 2'd0;
    e.addr = 13'd0;
    e.done = 1'b0;
    return e;
  endfunction

  // Monitor: compares the DUT against the head of the scoreboard queue.
  always @(negedge clk) begin
    logic [3:0] cmd;
    exp_t e;
    cmd = {cs_n, ras_n, cas_n, we_n};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL skipped_vector: expected cycle %0d, now at cycle %0d", e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      vectors++;
      if (cke !== e.cke || cmd !== e.cmd || ba !== e.ba || addr !== e.addr || init_done !== e.done) begin
        miscompares++;
        $display("FAIL cycle_%0d: got cke=%b cmd=%b ba=%0d addr=%h done=%b, want cke=%b cmd=%b ba=%0d addr=%h done=%b",
                 e.cyc, cke, cmd, ba, addr, init_done, e.cke, e.cmd, e.ba, e.addr, e.done);
      end
    end
    // No two non-NOP commands on consecutive cycles.
    if (!rst && prev_cmd != 4'b0111 && prev_cmd != 4'b1111) begin
      vectors++;
      if (cmd != 4'b0111) begin
        miscompares++;
        $display("FAIL back_to_back_cmd: got %b after %b, want 0111", cmd, prev_cmd);
      end
    end
    prev_cmd = rst ? 4'b1111 : cmd;
  end

  task automatic drain(input string name);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_%s: got %0d pending vectors, want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    q.push_back(exp_rst());
    drain("reset");
  endtask

  task automatic release_and_run(input int last);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= last; c++) q.push_back(exp_at(c));
  endtask

  initial begin
    // Reset state.
    q.push_back(exp_rst());
    drain("por");
    @(negedge clk);

    // Full sequence, then a few idle cycles in S_DONE.
    release_and_run(DONE_C + 5);
    drain("run_a");

    // Reset after init_done: returns to reset values, then full restart.
    assert_reset();

    // Interrupted run: reset lands mid-T_RFC at cycle 25.
    release_and_run(25);
    for (int i = 0; i < 200 && cyc != 25; i++) @(negedge clk);
    drain("run_b");
    #2;
    rst = 1'b1;
    q.push_back(exp_rst());
    drain("mid_reset");
    @(negedge clk);

    // Full restart with the complete T_WAIT.
    release_and_run(DONE_C + 5);
    drain("run_c");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
